// File: rtl/lock_cmd_initiator_if.sv
// Lock-core command bus: addressed strobe out, completion flag back.
interface lock_cmd_initiator_if;
   logic [15:0] addr;
   logic        en;
   logic [2:0]  cmd;
   logic        isDone;

   modport master (output addr, output en, output cmd, input isDone);
   modport slave  (input addr, input en, input cmd, output isDone);
endinterface

// File: rtl/lock_cmd_initiator.sv
// Lock-core command initiator: one addressed strobe per request, then completion
// supervision with a timeout, bounded retries and an idle gap between re-issues.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for req, outputs quiet
// ST_ISSUE | one-cycle en strobe with core_addr and cmd
// ST_WAIT  | watching for an isDone rising edge until timeout
// ST_GAP   | idle spacing before the next re-issue
module lock_cmd_initiator #(
   parameter logic [15:0] core_addr = 16'h16,
   parameter int unsigned TIMEOUT   = 200000000,
   parameter int unsigned RETRIES   = 2,
   parameter int unsigned GAP       = 16
) (
   input  logic                        clk,
   input  logic                        Reset,
   input  logic                        req,
   input  logic [2:0]                  req_cmd,
   lock_cmd_initiator_if.master        bus,
   output logic                        busy,
   output logic                        done,
   output logic                        fail,
   output logic [1:0]                  attempts
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [TW-1:0] TIMEOUT_TC   = TW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP - 1);
   localparam logic [2:0]    LAST_ATTEMPT = 3'(RETRIES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    cmd_cap_q, cmd_cap_d;
   logic [2:0]    att_q, att_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic          isdone_prev_q;
   logic          isdone_rise;

   logic [15:0]   addr_q, addr_d;
   logic          en_q, en_d;
   logic [2:0]    cmd_q, cmd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fail_q, fail_d;

   assign isdone_rise = bus.isDone & ~isdone_prev_q;

   always_comb begin
      state_d   = state_q;
      cmd_cap_d = cmd_cap_q;
      att_d     = att_q;
      tcnt_d    = tcnt_q;
      gcnt_d    = gcnt_q;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      en_d      = 1'b0;
      addr_d    = 16'h0000;
      cmd_d     = 3'd0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               cmd_cap_d = req_cmd;
               att_d     = 3'd1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // counter reads 1 in the first WAIT cycle
            tcnt_d  = TW'(1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (isdone_rise) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (tcnt_q == TIMEOUT_TC) begin
               if (att_q == LAST_ATTEMPT) begin
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  gcnt_d  = GAP_LOAD;
                  state_d = ST_GAP;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_GAP: begin
            if (gcnt_q == '0) begin
               att_d   = att_q + 3'd1;
               state_d = ST_ISSUE;
            end else begin
               gcnt_d = gcnt_q - GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // bus outputs are registered, so they follow the state being entered
      if (state_d == ST_ISSUE) begin
         en_d   = 1'b1;
         addr_d = core_addr;
         cmd_d  = cmd_cap_d;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         cmd_cap_q     <= 3'd0;
         att_q         <= 3'd0;
         tcnt_q        <= '0;
         gcnt_q        <= '0;
         isdone_prev_q <= 1'b0;
         addr_q        <= 16'h0000;
         en_q          <= 1'b0;
         cmd_q         <= 3'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_cap_q     <= cmd_cap_d;
         att_q         <= att_d;
         tcnt_q        <= tcnt_d;
         gcnt_q        <= gcnt_d;
         isdone_prev_q <= bus.isDone;
         addr_q        <= addr_d;
         en_q          <= en_d;
         cmd_q         <= cmd_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fail_q        <= fail_d;
      end
   end

   assign bus.addr = addr_q;
   assign bus.en   = en_q;
   assign bus.cmd  = cmd_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign fail     = fail_q;
   // RETRIES can reach 3, so the attempt count itself needs a third bit
   assign attempts = att_q[2] ? 2'd3 : att_q[1:0];

endmodule

// File: tb/tb_lock_cmd_initiator.sv
// Bench for lock_cmd_initiator: timeline model of strobes/outcomes plus directed scenarios.
module tb_lock_cmd_initiator;
   localparam int T_OUT = 20;
   localparam int RETR  = 2;
   localparam int GAPC  = 4;
   localparam int PER   = 1 + T_OUT + GAPC;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       req = 1'b0;
   logic [2:0] req_cmd = 3'd0;
   logic       busy, done, fail;
   logic [1:0] attempts;

   lock_cmd_initiator_if bus_if();

   lock_cmd_initiator #(
      .core_addr(16'h16),
      .TIMEOUT(T_OUT),
      .RETRIES(RETR),
      .GAP(GAPC)
   ) dut (
      .clk(clk),
      .Reset(Reset),
      .req(req),
      .req_cmd(req_cmd),
      .bus(bus_if.master),
      .busy(busy),
      .done(done),
      .fail(fail),
      .attempts(attempts)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;

   // model: a request is a timeline of strobes PER cycles apart, each followed by a T_OUT-cycle window
   logic       m_active = 1'b0;
   int         m_t0 = 0;
   logic [2:0] m_cmd_cap = 3'd0;
   logic       m_prev = 1'b0;
   logic       m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_fail = 1'b0;
   logic [1:0] m_att = 2'd0;

   int         strobes[$];
   logic [2:0] strobe_cmds[$];
   int n_done = 0, n_fail = 0, last_done = 0, last_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      logic rise;
      int d, j, r;
      cyc++;
      m_done = 1'b0;
      m_fail = 1'b0;
      m_en   = 1'b0;
      if (Reset) begin
         m_active  = 1'b0;
         m_att     = 2'd0;
         m_busy    = 1'b0;
         m_prev    = 1'b0;
         m_cmd_cap = 3'd0;
      end else begin
         rise = bus_if.isDone && !m_prev;
         if (!m_active) begin
            if (req) begin
               m_active  = 1'b1;
               m_t0      = cyc;
               m_cmd_cap = req_cmd;
            end
         end else begin
            d = cyc - m_t0;
            if (d >= 2) begin
               j = (d - 2) / PER;
               r = (d - 2) % PER;
               if (r < T_OUT) begin
                  if (rise) begin
                     m_done   = 1'b1;
                     m_active = 1'b0;
                  end else if (r == T_OUT - 1 && j == RETR) begin
                     m_fail   = 1'b1;
                     m_active = 1'b0;
                  end
               end
            end
         end
         if (m_active) begin
            d = cyc - m_t0;
            m_en  = (d % PER == 0);
            m_att = (d / PER + 1 > 3) ? 2'd3 : 2'(d / PER + 1);
         end
         m_busy = m_active;
         m_prev = bus_if.isDone;
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         chk("en", 32'(bus_if.en), 32'(m_en));
         chk("addr", 32'(bus_if.addr), m_en ? 32'h16 : 32'h0);
         chk("cmd", 32'(bus_if.cmd), m_en ? 32'(m_cmd_cap) : 32'h0);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("fail", 32'(fail), 32'(m_fail));
         chk("attempts", 32'(attempts), 32'(m_att));
         if (bus_if.en === 1'b1) begin
            strobes.push_back(cyc);
            strobe_cmds.push_back(bus_if.cmd);
         end
         if (done === 1'b1) begin
            n_done++;
            last_done = cyc;
         end
         if (fail === 1'b1) begin
            n_fail++;
            last_fail = cyc;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b0) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_idle: busy still high after %0d cycles", bound);
      end
   endtask

   task automatic issue(input logic [2:0] c);
      req = 1'b1;
      req_cmd = c;
      step(1);
      req = 1'b0;
   endtask

   initial begin
      int d0, f0;
      bus_if.isDone = 1'b0;

      // 1: reset, basic success
      step(2);
      Reset = 1'b0;
      step(1);
      chk("rst_addr", 32'(bus_if.addr), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_attempts", 32'(attempts), 32'h0);
      issue(3'b101);
      chk("t1_en", 32'(bus_if.en), 32'h1);
      chk("t1_addr", 32'(bus_if.addr), 32'h16);
      chk("t1_cmd", 32'(bus_if.cmd), 32'h5);
      chk("t1_attempts", 32'(attempts), 32'h1);
      step(5);
      bus_if.isDone = 1'b1;
      step(1);
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_busy", 32'(busy), 32'h0);
      bus_if.isDone = 1'b0;
      step(1);
      chk("t1_done_one_cycle", 32'(done), 32'h0);
      chk("t1_attempts_after", 32'(attempts), 32'h1);

      // 2: exhausted retries
      strobes.delete();
      strobe_cmds.delete();
      d0 = n_done;
      f0 = n_fail;
      issue(3'b011);
      wait_idle(100);
      step(1);
      chk("t2_strobe_count", 32'(strobes.size()), 32'd3);
      if (strobes.size() == 3) begin
         chk("t2_spacing_1", 32'(strobes[1] - strobes[0]), 32'd25);
         chk("t2_spacing_2", 32'(strobes[2] - strobes[1]), 32'd25);
         chk("t2_fail_delay", 32'(last_fail - strobes[2]), 32'd21);
         chk("t2_cmd", 32'(strobe_cmds[2]), 32'h3);
      end
      chk("t2_fail_count", 32'(n_fail - f0), 32'd1);
      chk("t2_no_done", 32'(n_done - d0), 32'd0);
      chk("t2_attempts", 32'(attempts), 32'd3);

      // 3: stale isDone level ignored, success on retry
      strobes.delete();
      strobe_cmds.delete();
      d0 = n_done;
      bus_if.isDone = 1'b1;
      step(3);
      issue(3'b010);
      step(3);
      bus_if.isDone = 1'b0;
      step(27);
      bus_if.isDone = 1'b1;
      wait_idle(60);
      step(1);
      bus_if.isDone = 1'b0;
      chk("t3_done_count", 32'(n_done - d0), 32'd1);
      chk("t3_strobe_count", 32'(strobes.size()), 32'd2);
      if (strobes.size() == 2)
         chk("t3_done_delay", 32'(last_done - strobes[1]), 32'd6);
      chk("t3_attempts", 32'(attempts), 32'd2);

      // 4: dropped requests, completion and timeout together
      strobes.delete();
      strobe_cmds.delete();
      d0 = n_done;
      f0 = n_fail;
      step(2);
      issue(3'b110);
      step(5);
      req = 1'b1;
      req_cmd = 3'b001;
      step(1);
      req = 1'b0;
      req_cmd = 3'b000;
      step(16);
      req = 1'b1;
      req_cmd = 3'b111;
      step(1);
      req = 1'b0;
      req_cmd = 3'b000;
      step(22);
      bus_if.isDone = 1'b1;
      step(1);
      chk("t4_done_at_tc", 32'(done), 32'h1);
      chk("t4_busy", 32'(busy), 32'h0);
      bus_if.isDone = 1'b0;
      step(30);
      chk("t4_strobe_count", 32'(strobes.size()), 32'd2);
      if (strobes.size() == 2)
         chk("t4_cmd_kept", 32'(strobe_cmds[1]), 32'h6);
      chk("t4_done_count", 32'(n_done - d0), 32'd1);
      chk("t4_no_fail", 32'(n_fail - f0), 32'd0);
      chk("t4_attempts", 32'(attempts), 32'd2);

      // 5: reset in WAIT cycle 7
      strobes.delete();
      strobe_cmds.delete();
      d0 = n_done;
      f0 = n_fail;
      issue(3'b100);
      step(7);
      Reset = 1'b1;
      step(1);
      chk("t5_en", 32'(bus_if.en), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_attempts", 32'(attempts), 32'h0);
      chk("t5_done", 32'(done), 32'h0);
      chk("t5_fail", 32'(fail), 32'h0);
      Reset = 1'b0;
      step(30);
      chk("t5_no_done", 32'(n_done - d0), 32'd0);
      chk("t5_no_fail", 32'(n_fail - f0), 32'd0);
      chk("t5_strobe_count", 32'(strobes.size()), 32'd1);
      issue(3'b011);
      chk("t5_new_en", 32'(bus_if.en), 32'h1);
      chk("t5_new_attempts", 32'(attempts), 32'h1);
      chk("t5_new_cmd", 32'(bus_if.cmd), 32'h3);
      wait_idle(100);
      step(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
